// File: rtl/spk_peak_det.sv
// spk_peak_det: per-channel threshold-and-trough detector.
// Takes a time-interleaved sample stream, one channel per valid cycle, and passes each sample
// through with one cycle of latency. Each output beat is annotated with that channel's
// detection state, running minimum and a one-beat peak flag.
// Build option SPK_PEAK_REFRACTORY_EN adds a per-channel refractory countdown after each peak.
// Without that option, ARMED returns straight to IDLE on a peak.
module spk_peak_det #(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned WIDTH_CH   = $clog2(NUM_CH),
  parameter int unsigned REFRACTORY = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         frame_No_in,
  input  logic [WIDTH_CH-1:0] ch_in,
  input  logic [31:0]         ch_unigroup_in,
  input  logic                eof_in,
  input  logic                valid_in,
  input  logic signed [31:0]  v_in,
  input  logic signed [31:0]  thr_in,
  output logic [31:0]         frame_No_out,
  output logic [WIDTH_CH-1:0] ch_out,
  output logic [31:0]         ch_unigroup_out,
  output logic                eof_out,
  output logic                valid_out,
  output logic signed [31:0]  v_out,
  output logic signed [31:0]  min_out,
  output logic [1:0]          state_out,
  output logic                is_peak_out
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRefract = 2'd2
  } ch_state_e;

  // Per-channel storage
  ch_state_e          state_q [NUM_CH];
  logic signed [31:0] min_q   [NUM_CH];

`ifdef SPK_PEAK_REFRACTORY_EN
  localparam logic [7:0] RefractLoad = 8'(REFRACTORY);
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cur_cnt, nxt_cnt;
`else
  logic [7:0] unused_refractory;
  assign unused_refractory = 8'(REFRACTORY);
`endif

  // Output registers
  logic [31:0]         frame_q, unigroup_q;
  logic [WIDTH_CH-1:0] ch_q;
  logic                eof_q, valid_q, peak_q;
  logic signed [31:0]  v_q, min_out_q;
  logic [1:0]          state_out_q;

  logic               ch_hit;
  ch_state_e          cur_state, nxt_state;
  logic signed [31:0] cur_min, nxt_min;
  logic               peak;

  // Storage is only touched for valid samples on an implemented channel
  assign ch_hit = valid_in && (32'(ch_in) < NUM_CH);

  // Read the addressed channel's stored context
  always_comb begin
    cur_state = StIdle;
    cur_min   = '0;
    if (ch_hit) begin
      cur_state = state_q[ch_in];
      cur_min   = min_q[ch_in];
    end
  end

`ifdef SPK_PEAK_REFRACTORY_EN
  // Read the addressed channel's refractory counter
  always_comb begin
    cur_cnt = '0;
    if (ch_hit) cur_cnt = cnt_q[ch_in];
  end
`endif

  // Per-channel detection state machine, next-state for the addressed channel
  always_comb begin
    nxt_state = cur_state;
    nxt_min   = cur_min;
    peak      = 1'b0;
`ifdef SPK_PEAK_REFRACTORY_EN
    nxt_cnt   = cur_cnt;
`endif
    case (cur_state)
      StArmed: begin
        if (v_in < cur_min) begin
          nxt_min = v_in;
        end else if (v_in > cur_min) begin
          // First sample after the trough; min stays at the trough value
          peak = 1'b1;
`ifdef SPK_PEAK_REFRACTORY_EN
          nxt_state = StRefract;
          nxt_cnt   = RefractLoad;
`else
          nxt_state = StIdle;
`endif
        end
      end
`ifdef SPK_PEAK_REFRACTORY_EN
      StRefract: begin
        // Leave on the sample where the count reaches zero; crossings are ignored here
        if (cur_cnt <= 8'd1) begin
          nxt_cnt   = '0;
          nxt_state = StIdle;
        end else begin
          nxt_cnt = cur_cnt - 8'd1;
        end
      end
`endif
      default: begin
        // IDLE, plus any encoding that should never be stored
        nxt_state = StIdle;
        if (v_in < thr_in) begin
          nxt_state = StArmed;
          nxt_min   = v_in;
        end
      end
    endcase
  end

  // Write back the addressed channel's context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= StIdle;
        min_q[i]   <= '0;
      end
    end else if (ch_hit) begin
      state_q[ch_in] <= nxt_state;
      min_q[ch_in]   <= nxt_min;
    end
  end

`ifdef SPK_PEAK_REFRACTORY_EN
  // Refractory counter write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else if (ch_hit) begin
      cnt_q[ch_in] <= nxt_cnt;
    end
  end
`endif

  // Output pipeline stage; annotations hold across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= '0;
      ch_q        <= '0;
      unigroup_q  <= '0;
      eof_q       <= 1'b0;
      valid_q     <= 1'b0;
      v_q         <= '0;
      min_out_q   <= '0;
      state_out_q <= '0;
      peak_q      <= 1'b0;
    end else begin
      frame_q    <= frame_No_in;
      ch_q       <= ch_in;
      unigroup_q <= ch_unigroup_in;
      eof_q      <= eof_in;
      valid_q    <= valid_in;
      v_q        <= v_in;
      peak_q     <= ch_hit && peak;
      if (ch_hit) begin
        state_out_q <= nxt_state;
        min_out_q   <= nxt_min;
      end else if (valid_in) begin
        state_out_q <= '0;
        min_out_q   <= '0;
      end
    end
  end

  assign frame_No_out    = frame_q;
  assign ch_out          = ch_q;
  assign ch_unigroup_out = unigroup_q;
  assign eof_out         = eof_q;
  assign valid_out       = valid_q;
  assign v_out           = v_q;
  assign min_out         = min_out_q;
  assign state_out       = state_out_q;
  assign is_peak_out     = peak_q;

endmodule

// File: tb/tb_spk_peak_det.sv
// Directed bench for spk_peak_det; expectations adapt to SPK_PEAK_REFRACTORY_EN.
module tb_spk_peak_det;

  localparam int unsigned NumCh   = 12;
  localparam int unsigned WidthCh = 4;
`ifdef SPK_PEAK_REFRACTORY_EN
  localparam int RefrEn = 1;
`else
  localparam int RefrEn = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [31:0]         frame_No_in, ch_unigroup_in;
  logic [WidthCh-1:0]  ch_in;
  logic                eof_in, valid_in;
  logic signed [31:0]  v_in, thr_in;
  logic [31:0]         frame_No_out, ch_unigroup_out;
  logic [WidthCh-1:0]  ch_out;
  logic                eof_out, valid_out, is_peak_out;
  logic signed [31:0]  v_out, min_out;
  logic [1:0]          state_out;

  always #5 clk = ~clk;

  spk_peak_det #(
    .NUM_CH    (NumCh),
    .WIDTH_CH  (WidthCh),
    .REFRACTORY(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_No_in    (frame_No_in),
    .ch_in          (ch_in),
    .ch_unigroup_in (ch_unigroup_in),
    .eof_in         (eof_in),
    .valid_in       (valid_in),
    .v_in           (v_in),
    .thr_in         (thr_in),
    .frame_No_out   (frame_No_out),
    .ch_out         (ch_out),
    .ch_unigroup_out(ch_unigroup_out),
    .eof_out        (eof_out),
    .valid_out      (valid_out),
    .v_out          (v_out),
    .min_out        (min_out),
    .state_out      (state_out),
    .is_peak_out    (is_peak_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Present one sample just after an edge, then step to just after the edge that registers it
  task automatic send(input int ch, input int v, input int thr, input int frame, input bit vld);
    ch_in          = ch[WidthCh-1:0];
    v_in           = v;
    thr_in         = thr;
    frame_No_in    = frame;
    ch_unigroup_in = frame ^ 32'h5A5A_0000;
    eof_in         = frame[0];
    valid_in       = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input int st, input int mn, input int pk);
    check({tag, ".state"}, state_out, st);
    check({tag, ".min"}, min_out, mn);
    check({tag, ".peak"}, is_peak_out, pk);
  endtask

  int tr_v  [5];
  int tr_st [5];
  int tr_mn [5];
  int rf_st [5];
  int rf_mn [5];

  initial begin
    tr_v  = '{0, -50, -120, -200, -150};
    tr_st = '{0, 0, 1, 1, (RefrEn != 0) ? 2 : 0};
    tr_mn = '{0, 0, -120, -200, -200};
    if (RefrEn != 0) begin
      rf_st = '{2, 2, 2, 0, 1};
      rf_mn = '{-200, -200, -200, -200, -300};
    end else begin
      rf_st = '{1, 1, 1, 1, 1};
      rf_mn = '{-300, -300, -300, -300, -300};
    end

    rst_n          = 1'b0;
    ch_in          = '0;
    v_in           = '0;
    thr_in         = '0;
    frame_No_in    = '0;
    ch_unigroup_in = '0;
    eof_in         = 1'b0;
    valid_in       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state after three idle cycles
    repeat (3) send(0, 0, 0, 0, 1'b0);
    check("rst.valid", valid_out, 0);
    check("rst.frame", frame_No_out, 0);
    check("rst.v", v_out, 0);
    expect_beat("rst", 0, 0, 0);

    // First valid sample, above threshold
    send(5, -10, -100, 1, 1'b1);
    check("first.valid", valid_out, 1);
    check("first.ch", ch_out, 5);
    check("first.v", v_out, -10);
    check("first.frame", frame_No_out, 1);
    check("first.unigroup", ch_unigroup_out, 32'h5A5A_0001);
    check("first.eof", eof_out, 1);
    expect_beat("first", 0, 0, 0);

    // Single-channel peak trace on ch 2
    for (int i = 0; i < 5; i++) begin
      send(2, tr_v[i], -100, 10 + i, 1'b1);
      expect_beat($sformatf("ch2.f%0d", 10 + i), tr_st[i], tr_mn[i], (i == 4) ? 1 : 0);
    end
    check("ch2.peak_frame", frame_No_out, 14);

    // Idle cycle: annotations hold, data still registered
    send(2, 123, -100, 99, 1'b0);
    check("idle.valid", valid_out, 0);
    check("idle.v", v_out, 123);
    expect_beat("idle", tr_st[4], -200, 0);

    // Refractory countdown (or immediate re-arm without it)
    for (int i = 0; i < 5; i++) begin
      send(2, -300, -100, 15 + i, 1'b1);
      expect_beat($sformatf("ch2.post%0d", i), rf_st[i], rf_mn[i], 0);
    end

    // Interleaved ch 3 / ch 7
    for (int i = 0; i < 5; i++) begin
      send(3, tr_v[i], -100, 30 + i, 1'b1);
      expect_beat($sformatf("ch3.%0d", i), tr_st[i], tr_mn[i], (i == 4) ? 1 : 0);
      send(7, -20, -100, 30 + i, 1'b1);
      check($sformatf("ch7.%0d.ch", i), ch_out, 7);
      expect_beat($sformatf("ch7.%0d", i), 0, 0, 0);
    end

    // Channel outside NUM_CH: passed through, no annotations
    send(13, -1000, -100, 50, 1'b1);
    check("oor.valid", valid_out, 1);
    check("oor.ch", ch_out, 13);
    expect_beat("oor", 0, 0, 0);

    // Arm ch 1, then reset mid-stream
    send(1, -500, -100, 60, 1'b1);
    expect_beat("ch1.arm", 1, -500, 0);
    rst_n = 1'b0;
    #1;
    check("arst.valid", valid_out, 0);
    check("arst.v", v_out, 0);
    expect_beat("arst", 0, 0, 0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, -400, -100, 61, 1'b1);
    expect_beat("ch1.after_rst", 1, -400, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spk_peak_det.md
# spk_peak_det

Per-channel threshold-and-trough detector sitting directly upstream of the spike-detection/extraction stage. Consumes the time-interleaved filtered MUA sample stream (one channel per valid cycle) and keeps an independent detection state machine per channel. Passes each sample through with one cycle of latency, annotated with the channel's detection state, running minimum and a one-cycle peak flag. These annotations feed the downstream `state_in`, `min_in` and `is_peak_in` inputs.

## Interface
- `NUM_CH`, 32: number of channels; state is kept for channels 0..NUM_CH-1.
- `WIDTH_CH`, `$clog2(NUM_CH)`: channel index width.
- `REFRACTORY`, 16: number of same-channel samples held in REFRACT after a peak, range 1..255.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_No_in` in 32: frame number of the sample.
- `ch_in` in WIDTH_CH: channel of the sample.
- `ch_unigroup_in` in 32: channel-group word; passed through unchanged.
- `eof_in` in 1: end-of-frame marker; passed through.
- `valid_in` in 1: sample strobe.
- `v_in` in 32 signed: filtered sample.
- `thr_in` in 32 signed: detection threshold, normally negative; sampled with `valid_in`.
- `frame_No_out`, `ch_out`, `ch_unigroup_out`, `eof_out`, `valid_out`, `v_out` out, same widths as inputs: registered copies of the inputs.
- `min_out` out 32 signed: the channel's running minimum after this sample.
- `state_out` out 2: the channel's state after this sample. Encoding: 0 IDLE, 1 ARMED, 2 REFRACT.
- `is_peak_out` out 1: high for one output beat when a trough is confirmed.

## Operation
- Per-channel storage: `state[NUM_CH]` (2 bits), `min[NUM_CH]` (32 bits signed), `cnt[NUM_CH]` (8 bits).
- Storage is read and updated only on cycles with `valid_in`=1 and `ch_in` < NUM_CH.
- All comparisons are signed 32-bit.
- Transitions for the addressed channel:
  - IDLE: if `v_in` < `thr_in` (strict), go to ARMED and set min = `v_in`. Otherwise stay in IDLE; min is unchanged.
  - ARMED: if `v_in` < min, set min = `v_in` and stay. If `v_in` == min, stay. If `v_in` > min, assert `is_peak_out` for this beat, load cnt = REFRACTORY and go to REFRACT. `min_out` on the peak beat is the trough value.
  - The peak beat is the first sample after the trough. `frame_No_out` on that beat is trough frame + 1; downstream subtracts 1.
  - REFRACT: decrement cnt on each sample of the channel; go to IDLE on the sample where cnt reaches 0. Threshold crossings are ignored while in REFRACT. min is held.
  - Stored state 3 is never produced; if read, it is treated as IDLE.
- A sample with `ch_in` >= NUM_CH is passed through with `state_out`=0, `min_out`=0, `is_peak_out`=0, and no storage is touched.
- Channels are fully independent. Back-to-back samples on the same channel see the state written on the previous edge; there is no read-after-write hazard.

## Timing
- Latency is 1 cycle from input to all outputs. There is no backpressure; one sample can be accepted every cycle.
- On a cycle with `valid_in`=0:
  - `valid_out` and `is_peak_out` are 0 on the next cycle.
  - The data outputs still register the inputs.
  - `state_out` and `min_out` hold their previous values.
- Reset values:
  - All outputs are 0.
  - All channel states are IDLE; all min and cnt entries are 0.
- Assertion of `rst_n` mid-ARMED or mid-REFRACT clears the channel immediately. The first sample after release is evaluated from IDLE.

## Configuration
- `SPK_PEAK_REFRACTORY_EN` defined: REFRACT behaves as described above, and `cnt` storage is built.
- Undefined:
  - On a peak, ARMED goes directly to IDLE. `state_out` on the peak beat is 0.
  - State 2 never appears, and no `cnt` storage is built.
  - The `REFRACTORY` parameter is ignored.

## Test plan
- Reset, then 3 idle cycles: all outputs are 0. A first valid sample on ch 5 with v=-10, thr=-100 gives `valid_out`=1 one cycle later, with state_out=0 and is_peak_out=0.
- Ch 2, thr=-100, v = 0, -50, -120, -200, -150 at frames 10..14:
  - state_out = 0, 0, 1, 1, 2.
  - min_out = 0, 0, -120, -200, -200.
  - is_peak_out=1 only on the frame-14 beat, with min_out=-200.
- Same trace as above, then 4 further ch 2 samples of -300 with REFRACTORY=4: state_out = 2, 2, 2, 0. A fifth sample of -300 gives state_out=1 and min_out=-300.
- Ch 3 and ch 7 alternate every cycle. Ch 3 follows the peak trace above; ch 7 stays at v=-20. Ch 7 shows state 0 throughout, and only ch 3 beats carry is_peak_out.
- Drive ch 1 into ARMED with min=-500, then pulse rst_n low mid-stream: outputs go to 0 immediately. After release, a ch 1 sample of v=-400 gives state_out=1 and min_out=-400.
- Macro undefined, ch 2 peak trace: the peak beat shows state_out=0. The next sample of v=-300 gives state_out=1.
